pc_branch_ctrl: RTL
===================

# pc_branch_ctrl

Program-counter and branch-resolution stage of the single-cycle RISC-V core. It sits directly downstream of the branch comparator and consumes its six comparison flags (`beq`, `bne`, `blt`, `bge`, `bltu`, `bgeu`). It selects the condition using `funct3`, resolves JAL/JALR/branch targets and holds the architectural PC register. It gates PC updates with a stall/fetch handshake and raises a one-cycle trap on a misaligned taken target before vectoring to `TRAP_VEC`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `TRAP_VEC`, 32'h0000_0100, PC loaded after a misalignment trap
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  reset: asynchronous, active-low
- `beq, bne, blt, bge, bltu, bgeu`  in  1 each  comparison flags from the branch comparator
- `funct3`  in  3  branch condition select
- `branch`, `jal`, `jalr`  in  1 each  control decode for the current instruction
- `imm`  in  32  sign-extended immediate
- `rs1`  in  32  base register value for JALR
- `stall`  in  1  hold PC this cycle
- `fetch_ready`  in  1  instruction memory accepts a new address
- `pc`  out  32  current PC (registered)
- `pc_plus4`  out  32  `pc+4`, the link value for JAL/JALR
- `taken`  out  1  combinational redirect decision
- `misalign_trap`  out  1  registered one-cycle trap pulse
- `trap_addr`  out  32  offending target, registered
- `branch_count`, `taken_count`  out  32 each  statistics counters (see Configuration)

## Operation
- States: RUN, TRAP.
- `advance = (state==RUN) & !stall & fetch_ready`.
- Condition select by `funct3`:
  - 000 → `beq`; 001 → `bne`; 100 → `blt`; 101 → `bge`; 110 → `bltu`; 111 → `bgeu`.
  - 010 and 011 → condition false (never taken).
- Priority when several controls are asserted: `jalr` > `jal` > `branch`.
- Targets:
  - JALR: `(rs1+imm) & ~32'h1`.
  - JAL and branch: `pc+imm`.
  - All arithmetic is 32-bit modulo; carries are discarded.
- `taken = jalr | jal | (branch & cond)`.
- `next_pc = taken ? target : pc+4`. Wrap-around is modular: 32'hFFFF_FFFC + 4 = 0.
- Misalignment is `taken & (target[1:0] != 0)`, evaluated only when `advance` is high.
- RUN, advance, no misalignment: `pc <= next_pc`.
- RUN, advance, misalignment:
  - `pc` holds its value.
  - `trap_addr <= target`, `misalign_trap <= 1`, state → TRAP.
- RUN, no advance: all registers hold.
- TRAP:
  - Unconditionally, `pc <= TRAP_VEC`, `misalign_trap <= 0`, state → RUN.
  - `stall` and `fetch_ready` are ignored in TRAP.
- `taken` is driven in every state. It is a pure function of the inputs and `pc`.

## Timing
- `taken`, target and `pc_plus4` are combinational from the inputs and `pc`, with zero latency.
- `pc` updates one rising edge after a cycle in which `advance` is high.
- `misalign_trap` is high for exactly one cycle, the cycle the FSM is in TRAP. `pc` equals `TRAP_VEC` in the following cycle.
- `trap_addr` holds its value until the next trap.
- Reset values: `pc=RESET_PC`, state RUN, `misalign_trap=0`, `trap_addr=0`, `branch_count=0`, `taken_count=0`.
- Reset asserted mid-TRAP: reset wins immediately (asynchronous); the FSM returns to RUN with `pc=RESET_PC` and no trap vectoring.
- `stall` and `fetch_ready` low on the same cycle: hold; the first cause seen has no priority over the other.

## Configuration
- Macro: `BRANCH_STATS_EN`.
- Defined:
  - `branch_count` increments on `advance & branch & !jal & !jalr`.
  - `taken_count` increments when that condition holds and `cond` is true.
  - Both counters saturate at 32'hFFFF_FFFF.
  - A misaligned taken branch still counts in both.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

## Test plan
- Reset release with `RESET_PC`=0: `pc`=0. Then 3 cycles with no control, `fetch_ready`=1, `stall`=0 → `pc` = 4, 8, 12.
- `pc`=0x40, `branch`=1, `funct3`=001, `bne`=1, `imm`=0x20 → `taken`=1; next `pc`=0x60. Same stimulus with `funct3`=010 → next `pc`=0x44.
- `jalr`=1, `rs1`=0x1001, `imm`=0x10 → target 0x1010; next `pc`=0x1010; `pc_plus4` equals old `pc`+4 during the instruction.
- `pc`=0x80, `jal`=1, `imm`=0x6 → `pc` holds 0x80, `misalign_trap` pulses for 1 cycle, `trap_addr`=0x86; the following cycle `pc`=0x100.
- `stall`=1 with a taken branch pending → `pc` unchanged and, with the macro on, `branch_count` unchanged. Release `stall` → `pc` redirects and `branch_count`/`taken_count` each increment by 1.
- `pc`=0xFFFF_FFFC, no control → next `pc`=0. Assert `rst_n`=0 during TRAP → `pc`=`RESET_PC` immediately and `misalign_trap`=0.

Source files
------------

// File: rtl/pc_branch_ctrl_if.sv
// ============================================================================
// Module   : pc_branch_ctrl_if
// Purpose  : Comparator flags, decode controls and PC/trap results exchanged
//            between the core datapath and the PC/branch stage.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface pc_branch_ctrl_if;
  logic        beq, bne, blt, bge, bltu, bgeu;
  logic [2:0]  funct3;
  logic        branch, jal, jalr;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        stall;
  logic        fetch_ready;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        taken;
  logic        misalign_trap;
  logic [31:0] trap_addr;
  logic [31:0] branch_count;
  logic [31:0] taken_count;

  modport master (
    output beq, bne, blt, bge, bltu, bgeu, funct3, branch, jal, jalr,
           imm, rs1, stall, fetch_ready,
    input  pc, pc_plus4, taken, misalign_trap, trap_addr,
           branch_count, taken_count
  );

  modport slave (
    input  beq, bne, blt, bge, bltu, bgeu, funct3, branch, jal, jalr,
           imm, rs1, stall, fetch_ready,
    output pc, pc_plus4, taken, misalign_trap, trap_addr,
           branch_count, taken_count
  );
endinterface

`default_nettype wire

// File: rtl/pc_branch_ctrl.sv
// ============================================================================
// Module   : pc_branch_ctrl
// Purpose  : PC register, branch/jump resolution and misaligned-target trap.
//            Optional statistics counters enabled by macro BRANCH_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_branch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  pc_branch_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] trap_addr_q, trap_addr_d;
  logic        trap_q, trap_d;

  logic        w_cond;
  logic        w_taken;
  logic        w_advance;
  logic        w_misalign;
  logic [31:0] w_target;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;

  // funct3 010/011 are not branch encodings and never redirect
  always_comb begin
    w_cond = 1'b0;
    case (bus.funct3)
      3'b000:  w_cond = bus.beq;
      3'b001:  w_cond = bus.bne;
      3'b100:  w_cond = bus.blt;
      3'b101:  w_cond = bus.bge;
      3'b110:  w_cond = bus.bltu;
      3'b111:  w_cond = bus.bgeu;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pc_plus4 = pc_q + 32'd4;
  assign w_target   = bus.jalr ? ((bus.rs1 + bus.imm) & ~32'h1) : (pc_q + bus.imm);
  assign w_taken    = bus.jalr | bus.jal | (bus.branch & w_cond);
  assign w_next_pc  = w_taken ? w_target : w_pc_plus4;
  assign w_advance  = (state_q == ST_RUN) & ~bus.stall & bus.fetch_ready;
  assign w_misalign = w_advance & w_taken & (w_target[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      trap_addr_q <= 32'h0;
      trap_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      trap_addr_q <= trap_addr_d;
      trap_q      <= trap_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    trap_addr_d = trap_addr_q;
    trap_d      = trap_q;
    case (state_q)
      ST_RUN: begin
        if (w_misalign) begin
          trap_addr_d = w_target;
          trap_d      = 1'b1;
          state_d     = ST_TRAP;
        end else if (w_advance) begin
          pc_d = w_next_pc;
        end
      end
      ST_TRAP: begin
        pc_d    = TRAP_VEC;
        trap_d  = 1'b0;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = w_pc_plus4;
  assign bus.taken         = w_taken;
  assign bus.misalign_trap = trap_q;
  assign bus.trap_addr     = trap_addr_q;

`ifdef BRANCH_STATS_EN
  logic [31:0] branch_count_q, taken_count_q;
  logic        w_count_en;

  // A branch shadowed by a jump is not a branch; misaligned branches still count
  assign w_count_en = w_advance & bus.branch & ~bus.jal & ~bus.jalr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count_q <= 32'h0;
      taken_count_q  <= 32'h0;
    end else begin
      if (w_count_en && branch_count_q != 32'hFFFF_FFFF)
        branch_count_q <= branch_count_q + 32'd1;
      if (w_count_en && w_cond && taken_count_q != 32'hFFFF_FFFF)
        taken_count_q <= taken_count_q + 32'd1;
    end
  end

  assign bus.branch_count = branch_count_q;
  assign bus.taken_count  = taken_count_q;
`else
  assign bus.branch_count = 32'h0;
  assign bus.taken_count  = 32'h0;
`endif

endmodule

`default_nettype wire
